// File: rtl/act_lane_scheduler.sv
// act_lane_scheduler: shares one 2-lane in-order pipelined sigmoid engine among NUM_REQ
// requester streams.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_last       per-requester beat valid and end-of-packet
//   req_x0/req_x1            packed lane operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready                per-requester accept (one-hot or zero)
//   eng_rst_n                engine reset (~rst)
//   eng_x0/eng_x1            registered engine operands
//   eng_valid_in             registered engine issue strobe
//   eng_y0/eng_y1            engine results
//   eng_valid_out            engine result strobe
//   res_valid/res_ready      result handshake, first-word-fall-through output FIFO
//   res_id/res_y0/res_y1     head result and its originating requester
//   busy                     results outstanding
//   err                      sticky: engine produced a result with no tag
//
// Arbitration is round-robin with packet locking. Issue is credit-limited by the number of
// outstanding results, so neither the tag FIFO nor the output FIFO can overflow.
module act_lane_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [DATA_W*NUM_REQ-1:0]   req_x0,
  input  logic [DATA_W*NUM_REQ-1:0]   req_x1,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        eng_rst_n,
  output logic [DATA_W-1:0]           eng_x0,
  output logic [DATA_W-1:0]           eng_x1,
  output logic                        eng_valid_in,
  input  logic [DATA_W-1:0]           eng_y0,
  input  logic [DATA_W-1:0]           eng_y1,
  input  logic                        eng_valid_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic [DATA_W-1:0]           res_y0,
  output logic [DATA_W-1:0]           res_y1,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ID_W + 2 * DATA_W;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e             state_q;
  logic [ID_W-1:0]    lock_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   outstanding_q;
  logic               err_q;

  logic [ID_W-1:0]    tag_mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]   tag_wr_q, tag_rd_q;
  logic [CNT_W-1:0]   tag_cnt_q;

  logic [ENT_W-1:0]   out_mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]   out_wr_q, out_rd_q;
  logic [CNT_W-1:0]   out_cnt_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  int unsigned        scan_idx;
  logic               credit_ok;
  logic               hs, hs_last;
  logic [ID_W-1:0]    rr_next;
  logic               tag_empty, ret_push, res_pop;
  logic [ENT_W-1:0]   out_head;

  // Grant is computed without regard to credit; credit only gates req_ready.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (state_q == StLock) begin
      if (req_valid[lock_id_q]) begin
        grant[lock_id_q] = 1'b1;
        grant_id         = lock_id_q;
      end
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!found && req_valid[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_id        = ID_W'(scan_idx);
          found           = 1'b1;
        end
      end
    end
  end

  // Credit uses the registered count only: a same-cycle pop does not open a slot.
  assign credit_ok = outstanding_q < CNT_W'(OUT_DEPTH);
  assign req_ready = (rst || !credit_ok) ? '0 : grant;
  assign hs        = |(req_valid & req_ready);
  assign hs_last   = req_last[grant_id];
  assign rr_next   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  assign eng_rst_n = ~rst;

  assign tag_empty = (tag_cnt_q == '0);
  assign ret_push  = eng_valid_out && !tag_empty;
  assign res_valid = (out_cnt_q != '0);
  assign res_pop   = res_valid && res_ready;
  assign out_head  = out_mem_q[out_rd_q];
  assign res_id    = res_valid ? out_head[ENT_W-1 -: ID_W] : '0;
  assign res_y0    = res_valid ? out_head[2*DATA_W-1 -: DATA_W] : '0;
  assign res_y1    = res_valid ? out_head[DATA_W-1:0] : '0;
  assign busy      = (outstanding_q != '0);
  assign err       = err_q;

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (hs) tag_mem_q[tag_wr_q] <= grant_id;
    if (ret_push) out_mem_q[out_wr_q] <= {tag_mem_q[tag_rd_q], eng_y0, eng_y1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StArb;
      lock_id_q     <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      eng_valid_in  <= 1'b0;
      eng_x0        <= '0;
      eng_x1        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      tag_cnt_q     <= '0;
      out_wr_q      <= '0;
      out_rd_q      <= '0;
      out_cnt_q     <= '0;
    end else begin
      eng_valid_in <= hs;
      if (hs) begin
        eng_x0 <= req_x0[grant_id*DATA_W +: DATA_W];
        eng_x1 <= req_x1[grant_id*DATA_W +: DATA_W];
        if (hs_last) begin
          rr_ptr_q <= rr_next;
          state_q  <= StArb;
        end else begin
          lock_id_q <= grant_id;
          state_q   <= StLock;
        end
      end

      if (eng_valid_out && tag_empty) err_q <= 1'b1;

      if (hs) tag_wr_q <= tag_wr_q + PTR_W'(1);
      if (ret_push) tag_rd_q <= tag_rd_q + PTR_W'(1);
      if (hs && !ret_push) tag_cnt_q <= tag_cnt_q + CNT_W'(1);
      else if (!hs && ret_push) tag_cnt_q <= tag_cnt_q - CNT_W'(1);

      if (ret_push) out_wr_q <= out_wr_q + PTR_W'(1);
      if (res_pop) out_rd_q <= out_rd_q + PTR_W'(1);
      if (ret_push && !res_pop) out_cnt_q <= out_cnt_q + CNT_W'(1);
      else if (!ret_push && res_pop) out_cnt_q <= out_cnt_q - CNT_W'(1);

      if (hs && !res_pop) outstanding_q <= outstanding_q + CNT_W'(1);
      else if (!hs && res_pop) outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_act_lane_scheduler.sv
// Testbench for act_lane_scheduler with a 3-cycle in-order stub sigmoid engine.
module tb_act_lane_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [DW*NR-1:0] req_x0, req_x1;
  logic            eng_rst_n, eng_valid_in, eng_valid_out;
  logic [DW-1:0]   eng_x0, eng_x1, eng_y0, eng_y1;
  logic            res_valid, res_ready, busy, err;
  logic [1:0]      res_id;
  logic [DW-1:0]   res_y0, res_y1;
  logic            force_vo = 1'b0;

  always #5 clk = ~clk;

  act_lane_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_x0(req_x0), .req_x1(req_x1), .req_ready(req_ready), .eng_rst_n(eng_rst_n),
    .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_valid_in(eng_valid_in), .eng_y0(eng_y0),
    .eng_y1(eng_y1), .eng_valid_out(eng_valid_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_y0(res_y0), .res_y1(res_y1),
    .busy(busy), .err(err)
  );

  // Stub engine: exact Q5.11 sigmoid for the operands used here, identity otherwise.
  function automatic logic [DW-1:0] sig(input logic [DW-1:0] x);
    case (x)
      16'h0000: sig = 16'h0400;
      16'h0800: sig = 16'h05D9;
      16'h1000: sig = 16'h070C;
      16'h1800: sig = 16'h079F;
      default:  sig = x;
    endcase
  endfunction

  logic [LAT-1:0] pv;
  logic [DW-1:0]  p0 [LAT];
  logic [DW-1:0]  p1 [LAT];
  always @(posedge clk) begin
    if (!eng_rst_n) pv <= '0;
    else pv <= {pv[LAT-2:0], eng_valid_in};
    p0[0] <= sig(eng_x0);
    p1[0] <= sig(eng_x1);
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign eng_valid_out = pv[LAT-1] | force_vo;
  assign eng_y0 = p0[LAT-1];
  assign eng_y1 = p1[LAT-1];

  // Expected sigmoid of 0x0800*k, k = 0..3.
  logic [DW-1:0] sig_exp [4];
  initial sig_exp = '{16'h0400, 16'h05D9, 16'h070C, 16'h079F};

  // Monitors: handshake count and popped results.
  int hs_cnt = 0;
  logic [35:0] res_log [$];
  always @(posedge clk) begin
    if (!rst) begin
      if (|(req_valid & req_ready)) hs_cnt++;
      if (res_valid && res_ready) res_log.push_back({2'b00, res_id, res_y0, res_y1});
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic set_x();
    for (int i = 0; i < NR; i++) begin
      req_x0[i*DW +: DW] = 16'(16'h0800 * i);
      req_x1[i*DW +: DW] = 16'(16'h0800 * (3 - i));
    end
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic [NR-1:0] rdy;
  } vec_t;

  vec_t tbl [13];
  logic [35:0] exp_q [$];

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int base;
    logic [1:0] eid;

    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[5]  = '{4'b0101, 4'b1111, 4'b0100};
    tbl[6]  = '{4'b0011, 4'b1111, 4'b0001};
    tbl[7]  = '{4'b0111, 4'b0101, 4'b0010};  // req1 opens a packet
    tbl[8]  = '{4'b0111, 4'b0101, 4'b0010};
    tbl[9]  = '{4'b0101, 4'b0101, 4'b0000};  // req1 drops valid: bubble
    tbl[10] = '{4'b0111, 4'b0111, 4'b0010};  // req1 closes packet
    tbl[11] = '{4'b0111, 4'b0111, 4'b0100};
    tbl[12] = '{4'b0111, 4'b0111, 4'b0001};

    // 1. Reset with random inputs
    rst = 1'b1;
    req_valid = NR'($urandom);
    req_last = NR'($urandom);
    req_x0 = {$urandom, $urandom};
    req_x1 = {$urandom, $urandom};
    res_ready = 1'($urandom);
    ticks(2);
    chk("reset_ctrl", {req_ready, eng_valid_in, res_valid, busy, err, eng_rst_n}, 0);
    chk("reset_data", {eng_x0, eng_x1, res_id, res_y0, res_y1}, 0);

    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_x0 = '0;
    req_x1 = '0;
    res_ready = 1'b1;
    tick();
    chk("eng_rst_n_release", eng_rst_n, 1);
    req_valid = 4'b0001;
    req_last = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_issue", {eng_valid_in, eng_x0, eng_x1}, {1'b1, 32'h0});
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_issue_drop", eng_valid_in, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (res_valid) ok = 1;
      else tick();
    end
    chk("t1_res_timeout", ok, 1);
    chk("t1_result", {res_id, res_y0, res_y1}, {2'd0, 16'h0400, 16'h0400});
    tick();
    chk("t1_busy_fall", {busy, res_valid}, 0);

    // 2/3. Round-robin and packet locking, table driven
    do_reset();
    res_log.delete();
    exp_q.delete();
    set_x();
    res_ready = 1'b1;
    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].v;
      req_last = tbl[r].l;
      #1;
      chk($sformatf("rr_row%0d", r), req_ready, tbl[r].rdy);
      for (int i = 0; i < NR; i++) begin
        if (tbl[r].rdy[i]) begin
          eid = 2'(i);
          exp_q.push_back({2'b00, eid, sig_exp[i], sig_exp[3-i]});
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    ticks(20);
    chk("rr_res_count", res_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < res_log.size(); i++)
      chk($sformatf("rr_res%0d", i), res_log[i], exp_q[i]);

    // 4. Backpressure: credit limit then a single pop
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    base = hs_cnt;
    ticks(20);
    chk("bp_issue_count", hs_cnt - base, 8);
    chk("bp_stalled", {req_ready, busy, res_valid}, {4'b0000, 1'b1, 1'b1});
    res_ready = 1'b1;
    #1;
    chk("bp_no_bypass", req_ready, 0);
    tick();
    res_ready = 1'b0;
    #1;
    chk("bp_credit_back", $countones(req_ready), 1);
    tick();
    ticks(5);
    chk("bp_one_more", hs_cnt - base, 9);

    // 5. Issue and pop in the same cycle at outstanding=5
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_last = 4'b0001;
    base = hs_cnt;
    ticks(5);
    req_valid = '0;
    ticks(8);
    chk("sim_filled", {res_valid, busy}, 2'b11);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #1;
    chk("sim_issue", req_ready, 4'b0001);
    tick();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    ticks(10);
    chk("sim_total", hs_cnt - base, 9);
    chk("sim_full", req_ready, 0);
    req_valid = '0;

    // 6. Error on untagged result, then reset with work in flight
    do_reset();
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    chk("err_set", {err, res_valid}, 2'b10);
    ticks(3);
    chk("err_sticky", {err, res_valid}, 2'b10);
    req_valid = 4'b0001;
    req_last = 4'b0001;
    ticks(4);
    req_valid = '0;
    rst = 1'b1;
    base = res_log.size();
    ticks(2);
    chk("rst_clear", {err, res_valid, busy, eng_rst_n}, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    ticks(12);
    chk("rst_no_stale", res_log.size(), base);
    chk("rst_quiet", {err, res_valid, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_lane_scheduler.md
Name: act_lane_scheduler

Overview:
Shares one 2-lane pipelined sigmoid engine (Q5.11 in/out, valid_in/valid_out, fixed in-order latency, no stall input) among NUM_REQ requester streams. It does round-robin arbitration with packet locking, tags each issued beat with the requester ID, and reorders nothing, because the engine is in-order. It returns results through a credit-protected output FIFO with a ready/valid handshake, so the engine never produces a result that has no buffer slot.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ) is a derived localparam.
DATA_W, 16, element width (Q5.11).
OUT_DEPTH, 8, output FIFO depth and credit limit (power of 2, ≥ engine latency + 2 for full throughput).

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  synchronous reset, active-high.
req_valid  in  NUM_REQ  per-requester beat valid.
req_last  in  NUM_REQ  beat ends packet.
req_x0  in  DATA_W*NUM_REQ  lane-0 operand; requester i occupies bits [i*DATA_W +: DATA_W].
req_x1  in  DATA_W*NUM_REQ  lane-1 operand; same packing.
req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
eng_rst_n  out  1  engine reset, equal to ~rst (combinational).
eng_x0, eng_x1  out  DATA_W  engine operands.
eng_valid_in  out  1  engine issue strobe.
eng_y0, eng_y1  in  DATA_W  engine results.
eng_valid_out  in  1  engine result strobe.
res_valid  out  1  result available.
res_ready  in  1  consumer accept.
res_id  out  ID_W  originating requester.
res_y0, res_y1  out  DATA_W  results.
busy  out  1  outstanding != 0.
err  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous): req_ready=0, eng_valid_in=0, eng_x0/x1=0, res_valid=0, res_id/res_y0/res_y1=0, busy=0, err=0. Both FIFOs empty, outstanding=0, rr_ptr=0, state=ARB. eng_rst_n is low while rst is high, so the engine pipeline is flushed together with the scheduler. Reset mid-operation discards all in-flight work and causes no err.
- Issue handshake: req_valid[i] & req_ready[i].
  - req_ready is combinational: grant[i] & credit_ok.
  - credit_ok = outstanding < OUT_DEPTH, computed from the registered count. There is no bypass: a pop in the same cycle does not enable an issue.
- Issue latency: eng_x0/eng_x1/eng_valid_in are registered and appear 1 cycle after the handshake. eng_valid_in is 0 in cycles with no handshake, and eng_x* hold their last value.
- Tag FIFO (depth OUT_DEPTH): pushes the granted ID on handshake and pops on eng_valid_out.
- Arbitration, state ARB:
  - grant goes to the first valid requester searching from rr_ptr upward, modulo NUM_REQ.
  - On a handshake with last=1, rr_ptr becomes i+1 mod NUM_REQ and the state stays ARB.
  - On a handshake with last=0, the state moves to LOCK(i) and rr_ptr is unchanged.
- Arbitration, state LOCK(i):
  - only requester i can be granted. If req_valid[i]=0, nothing issues; no other requester is granted.
  - On a handshake with last=1, rr_ptr becomes i+1 and the state returns to ARB.
- Return path: on eng_valid_out, {tag head, eng_y0, eng_y1} is pushed into the output FIFO and the tag is popped.
  - If eng_valid_out=1 while the tag FIFO is empty, err is set (sticky until rst) and the result is dropped.
- Output FIFO is first-word-fall-through: res_valid = !empty, and res_* show the head. Pop on res_valid & res_ready. While res_valid=1 and res_ready=0, res_* stay stable.
- outstanding: +1 on issue handshake, -1 on result pop, unchanged when both happen in the same cycle. Range 0..OUT_DEPTH.
  - This counter bounds tag FIFO and output FIFO occupancy, so neither FIFO can overflow.
  - Pointers wrap modulo OUT_DEPTH.
- Throughput: one beat (2 elements) per cycle when credit is available and res_ready=1.

Test Plan:
1. Reset: hold rst 2 cycles with random inputs → all outputs 0 and eng_rst_n=0. Release, then req0 sends x0=x1=0x0000, last=1 → eng_valid_in 1 cycle later with 0x0000. After engine latency: res_valid=1, res_id=0, res_y0=res_y1=0x0400, and busy falls after the pop.
2. Round-robin: all 4 requesters valid, last=1, res_ready=1 → handshake order 0,1,2,3,0,1… with one per cycle. The res_id sequence matches; x0 = 0x0800*id gives the matching sigmoid per id.
3. Lock: req1 sends 3 beats (last=0,0,1) while req0 and req2 are held valid → req1's beats issue back-to-back, then req2, then req0. A one-cycle req1 valid drop inside the packet → a 1-cycle issue bubble with no other grant.
4. Backpressure: res_ready=0, all requesters valid → exactly 8 issues, then req_ready=0000 and busy=1. Pulse res_ready for 1 cycle → exactly 1 further issue, occurring the cycle after the pop.
5. Simultaneous events: with outstanding=5, an issue and a pop in the same cycle → outstanding stays 5. With outstanding=8, a pop in cycle N → no issue in N, issue in N+1.
6. Error and reset: force eng_valid_out=1 with outstanding=0 → err=1, res_valid stays 0, err persists. Assert rst with 4 beats in flight → err=0, res_valid=0, no stale results after release.
